// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared constants and types for the JTAG instruction register
package jtag_pkg;

    // Default opcodes. EXTEST and BYPASS are all-zeros / all-ones at any width,
    // so only their replicated bit value is kept here.
    localparam logic DEFAULT_EXTEST_BIT = 1'b0;
    localparam logic DEFAULT_BYPASS_BIT = 1'b1;
    localparam int   DEFAULT_SAMPLE_OP  = 2;
    localparam int   DEFAULT_IDCODE_OP  = 1;

    // Fixed pattern loaded into the two LSBs on Capture-IR.
    localparam logic [1:0] CAPTURE_LSBS = 2'b01;

    // Minimum legal instruction length.
    localparam int MIN_IR_WIDTH = 2;

    // Decoded data-register selects driven towards the DR mux.
    typedef struct packed {
        logic sel_bypass;
        logic sel_idcode;
        logic sel_boundary;
        logic extest_mode;
    } ir_sel_t;

    // True when two opcodes of the given width collide.
    function automatic logic opcodes_equal(input logic [31:0] a, input logic [31:0] b);
        return (a == b);
    endfunction

endpackage

// File: rtl/ir_bit_cell.sv
// rtl/ir_bit_cell.sv - one instruction-register bit: shift flop plus update flop
import jtag_pkg::*;

module ir_bit_cell #(
    parameter logic RESET_Q = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_tlr_reset,
    input  logic i_capture_val,
    input  logic i_serial_in,
    input  logic i_capture_en,
    input  logic i_shift_en,
    input  logic i_update_en,
    output logic o_serial_out,
    output logic o_q
);

    logic r_shift;
    logic r_update;
    logic w_any_reset;

    assign w_any_reset  = i_reset | i_tlr_reset;
    assign o_serial_out = r_shift;
    assign o_q          = r_update;

    // Shift stage: reset wins, then capture, then shift; otherwise hold.
    always_ff @(posedge i_clk) begin
        if (w_any_reset) begin
            r_shift <= 1'b0;
        end else if (i_capture_en) begin
            r_shift <= i_capture_val;
        end else if (i_shift_en) begin
            r_shift <= i_serial_in;
        end
    end

    // Update stage: loads the pre-edge shift bit, so it runs in parallel with a shift.
    always_ff @(posedge i_clk) begin
        if (w_any_reset) begin
            r_update <= RESET_Q;
        end else if (i_update_en) begin
            r_update <= r_shift;
        end
    end

endmodule

// File: rtl/instruction_register.sv
// rtl/instruction_register.sv - parametrised JTAG instruction register with opcode decode
import jtag_pkg::*;

module instruction_register #(
    parameter int                  IR_WIDTH  = 4,
    parameter logic [IR_WIDTH-1:0] EXTEST_OP = {IR_WIDTH{DEFAULT_EXTEST_BIT}},
    parameter logic [IR_WIDTH-1:0] SAMPLE_OP = IR_WIDTH'(DEFAULT_SAMPLE_OP),
    parameter logic [IR_WIDTH-1:0] IDCODE_OP = IR_WIDTH'(DEFAULT_IDCODE_OP),
    parameter logic [IR_WIDTH-1:0] BYPASS_OP = {IR_WIDTH{DEFAULT_BYPASS_BIT}},
    localparam int                 DI_W      = (IR_WIDTH > 2) ? IR_WIDTH - 2 : 1
) (
    input  logic                ClockIR,
    input  logic                Reset,
    input  logic                TlrReset,
    input  logic                TDI,
    input  logic [DI_W-1:0]     DI,
    input  logic                CaptureIR,
    input  logic                ShiftIR,
    input  logic                UpdateIR,
    output logic                TDO,
    output logic [IR_WIDTH-1:0] Q,
    output logic                SelBypass,
    output logic                SelIdcode,
    output logic                SelBoundary,
    output logic                ExtestMode
);

    // Elaboration-time sanity checks on width and opcode uniqueness.
    if (IR_WIDTH < MIN_IR_WIDTH) begin : g_err_width
        $error("instruction_register: IR_WIDTH must be at least 2");
    end
    if (opcodes_equal(32'(EXTEST_OP), 32'(SAMPLE_OP)) ||
        opcodes_equal(32'(EXTEST_OP), 32'(IDCODE_OP)) ||
        opcodes_equal(32'(EXTEST_OP), 32'(BYPASS_OP)) ||
        opcodes_equal(32'(SAMPLE_OP), 32'(IDCODE_OP)) ||
        opcodes_equal(32'(SAMPLE_OP), 32'(BYPASS_OP)) ||
        opcodes_equal(32'(IDCODE_OP), 32'(BYPASS_OP))) begin : g_err_opcode
        $error("instruction_register: opcode parameters must be distinct");
    end

    logic [IR_WIDTH-1:0] w_capture_val;
    logic [IR_WIDTH-1:0] w_shift_reg;
    logic [IR_WIDTH-1:0] w_q;
    ir_sel_t             w_sel;

    // Capture value: status bits above the fixed 01 pattern; no status bits at width 2.
    if (IR_WIDTH > 2) begin : g_capture_di
        assign w_capture_val = {DI, CAPTURE_LSBS};
    end else begin : g_capture_nodi
        logic w_unused_di;
        assign w_unused_di   = ^DI;
        assign w_capture_val = IR_WIDTH'(CAPTURE_LSBS);
    end

    // One cell per bit; the chain shifts towards bit 0 with TDI entering at the MSB.
    for (genvar g = 0; g < IR_WIDTH; g++) begin : g_cell
        logic w_serial_in;

        if (g == IR_WIDTH - 1) begin : g_msb
            assign w_serial_in = TDI;
        end else begin : g_inner
            assign w_serial_in = w_shift_reg[g+1];
        end

        ir_bit_cell #(
            .RESET_Q (IDCODE_OP[g])
        ) u_cell (
            .i_clk         (ClockIR),
            .i_reset       (Reset),
            .i_tlr_reset   (TlrReset),
            .i_capture_val (w_capture_val[g]),
            .i_serial_in   (w_serial_in),
            .i_capture_en  (CaptureIR),
            .i_shift_en    (ShiftIR),
            .i_update_en   (UpdateIR),
            .o_serial_out  (w_shift_reg[g]),
            .o_q           (w_q[g])
        );
    end

    assign TDO = w_shift_reg[0];
    assign Q   = w_q;

    // Decode the active instruction; anything unrecognised falls back to BYPASS.
    always_comb begin
        w_sel = '0;
        if (w_q == EXTEST_OP) begin
            w_sel.sel_boundary = 1'b1;
            w_sel.extest_mode  = 1'b1;
        end else if (w_q == SAMPLE_OP) begin
            w_sel.sel_boundary = 1'b1;
        end else if (w_q == IDCODE_OP) begin
            w_sel.sel_idcode = 1'b1;
        end else begin
            w_sel.sel_bypass = 1'b1;
        end
    end

    assign SelBypass   = w_sel.sel_bypass;
    assign SelIdcode   = w_sel.sel_idcode;
    assign SelBoundary = w_sel.sel_boundary;
    assign ExtestMode  = w_sel.extest_mode;

endmodule

// File: tb/tb_instruction_register.sv
// tb/tb_instruction_register.sv - directed self-checking bench for instruction_register
`timescale 1ns/1ps

module tb_instruction_register;

    logic       clk;
    logic       Reset, TlrReset, TDI, CaptureIR, ShiftIR, UpdateIR;
    logic [1:0] DI;
    logic       TDO, SelBypass, SelIdcode, SelBoundary, ExtestMode;
    logic [3:0] Q;
    logic [3:0] sr;

    int n_cmp  = 0;
    int n_fail = 0;

    instruction_register #(.IR_WIDTH(4)) dut (
        .ClockIR     (clk),
        .Reset       (Reset),
        .TlrReset    (TlrReset),
        .TDI         (TDI),
        .DI          (DI),
        .CaptureIR   (CaptureIR),
        .ShiftIR     (ShiftIR),
        .UpdateIR    (UpdateIR),
        .TDO         (TDO),
        .Q           (Q),
        .SelBypass   (SelBypass),
        .SelIdcode   (SelIdcode),
        .SelBoundary (SelBoundary),
        .ExtestMode  (ExtestMode)
    );

    assign sr = dut.w_shift_reg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        Reset = 0; TlrReset = 0; TDI = 0; CaptureIR = 0; ShiftIR = 0; UpdateIR = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Shift four bits in, bit 0 first, leaving all enables low afterwards.
    task automatic shift_in(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            ShiftIR = 1; TDI = v[i];
            step();
        end
        idle();
    endtask

    task automatic do_update();
        UpdateIR = 1;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        Reset = 1; ShiftIR = 1; TDI = 1;
        step();
        idle();
        n_cmp++; if (Q !== 4'b0001) begin n_fail++; $display("FAIL reset_q got=%b exp=0001", Q); end
        n_cmp++; if (sr !== 4'b0000) begin n_fail++; $display("FAIL reset_sr got=%b exp=0000", sr); end
        n_cmp++; if (TDO !== 1'b0) begin n_fail++; $display("FAIL reset_tdo got=%b exp=0", TDO); end
        n_cmp++; if ({SelBypass, SelIdcode, SelBoundary, ExtestMode} !== 4'b0100) begin
            n_fail++; $display("FAIL reset_sel got=%b exp=0100", {SelBypass, SelIdcode, SelBoundary, ExtestMode}); end
    endtask

    task automatic test_capture();
        DI = 2'b10; CaptureIR = 1;
        step();
        idle();
        n_cmp++; if (sr !== 4'b1001) begin n_fail++; $display("FAIL capture_sr got=%b exp=1001", sr); end
        n_cmp++; if (TDO !== 1'b1) begin n_fail++; $display("FAIL capture_tdo got=%b exp=1", TDO); end
        n_cmp++; if (Q !== 4'b0001) begin n_fail++; $display("FAIL capture_q got=%b exp=0001", Q); end
    endtask

    task automatic test_shift_out_extest();
        logic [3:0] exp_tdo;
        exp_tdo = 4'b1001;  // element i is TDO seen before shift edge i
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (TDO !== exp_tdo[i]) begin n_fail++; $display("FAIL shift_tdo[%0d] got=%b exp=%b", i, TDO, exp_tdo[i]); end
            ShiftIR = 1; TDI = 0;
            step();
            n_cmp++; if (Q !== 4'b0001) begin n_fail++; $display("FAIL shift_q_stable[%0d] got=%b exp=0001", i, Q); end
        end
        idle();
        do_update();
        n_cmp++; if (Q !== 4'b0000) begin n_fail++; $display("FAIL extest_q got=%b exp=0000", Q); end
        n_cmp++; if ({SelBypass, SelIdcode, SelBoundary, ExtestMode} !== 4'b0011) begin
            n_fail++; $display("FAIL extest_sel got=%b exp=0011", {SelBypass, SelIdcode, SelBoundary, ExtestMode}); end
    endtask

    task automatic test_bypass_decode();
        shift_in(4'b0110);
        n_cmp++; if (sr !== 4'b0110) begin n_fail++; $display("FAIL unk_sr got=%b exp=0110", sr); end
        do_update();
        n_cmp++; if (Q !== 4'b0110) begin n_fail++; $display("FAIL unk_q got=%b exp=0110", Q); end
        n_cmp++; if ({SelBypass, SelIdcode, SelBoundary, ExtestMode} !== 4'b1000) begin
            n_fail++; $display("FAIL unk_sel got=%b exp=1000", {SelBypass, SelIdcode, SelBoundary, ExtestMode}); end
        shift_in(4'b1111);
        do_update();
        n_cmp++; if (Q !== 4'b1111) begin n_fail++; $display("FAIL bypass_q got=%b exp=1111", Q); end
        n_cmp++; if ({SelBypass, SelIdcode, SelBoundary, ExtestMode} !== 4'b1000) begin
            n_fail++; $display("FAIL bypass_sel got=%b exp=1000", {SelBypass, SelIdcode, SelBoundary, ExtestMode}); end
    endtask

    task automatic test_shift_update_same_cycle();
        shift_in(4'b0010);
        ShiftIR = 1; UpdateIR = 1; TDI = 1;
        step();
        idle();
        n_cmp++; if (Q !== 4'b0010) begin n_fail++; $display("FAIL concur_q got=%b exp=0010", Q); end
        n_cmp++; if (sr !== 4'b1001) begin n_fail++; $display("FAIL concur_sr got=%b exp=1001", sr); end
        n_cmp++; if ({SelBypass, SelIdcode, SelBoundary, ExtestMode} !== 4'b0010) begin
            n_fail++; $display("FAIL concur_sel got=%b exp=0010", {SelBypass, SelIdcode, SelBoundary, ExtestMode}); end
    endtask

    task automatic test_capture_priority_and_hold();
        DI = 2'b01; CaptureIR = 1; ShiftIR = 1; TDI = 1;
        step();
        idle();
        n_cmp++; if (sr !== 4'b0101) begin n_fail++; $display("FAIL cap_prio_sr got=%b exp=0101", sr); end
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (sr !== 4'b0101) begin n_fail++; $display("FAIL hold_sr got=%b exp=0101", sr); end
        n_cmp++; if (Q !== 4'b0010) begin n_fail++; $display("FAIL hold_q got=%b exp=0010", Q); end
    endtask

    task automatic test_tlr_reset();
        shift_in(4'b1111);
        do_update();
        n_cmp++; if (Q !== 4'b1111) begin n_fail++; $display("FAIL tlr_pre_q got=%b exp=1111", Q); end
        ShiftIR = 1; TDI = 1;
        step();
        step();
        TlrReset = 1;
        step();
        idle();
        n_cmp++; if (Q !== 4'b0001) begin n_fail++; $display("FAIL tlr_q got=%b exp=0001", Q); end
        n_cmp++; if (sr !== 4'b0000) begin n_fail++; $display("FAIL tlr_sr got=%b exp=0000", sr); end
        n_cmp++; if (SelIdcode !== 1'b1) begin n_fail++; $display("FAIL tlr_selid got=%b exp=1", SelIdcode); end
        DI = 2'b00; CaptureIR = 1;
        step();
        idle();
        n_cmp++; if (TDO !== 1'b1) begin n_fail++; $display("FAIL tlr_cap_tdo got=%b exp=1", TDO); end
        n_cmp++; if (sr !== 4'b0001) begin n_fail++; $display("FAIL tlr_cap_sr got=%b exp=0001", sr); end
    endtask

    task automatic test_reset_during_update();
        shift_in(4'b0000);
        do_update();
        n_cmp++; if (Q !== 4'b0000) begin n_fail++; $display("FAIL rstupd_pre_q got=%b exp=0000", Q); end
        shift_in(4'b1010);
        Reset = 1; UpdateIR = 1; CaptureIR = 1; DI = 2'b11;
        step();
        idle();
        n_cmp++; if (Q !== 4'b0001) begin n_fail++; $display("FAIL rstupd_q got=%b exp=0001", Q); end
        n_cmp++; if (sr !== 4'b0000) begin n_fail++; $display("FAIL rstupd_sr got=%b exp=0000", sr); end
    endtask

    initial begin
        idle();
        DI = 2'b00;
        step();
        test_reset();
        test_capture();
        test_shift_out_extest();
        test_bypass_decode();
        test_shift_update_same_cycle();
        test_capture_priority_and_hold();
        test_tlr_reset();
        test_reset_during_update();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
